// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted control transfers: recorded at preRR, resolved at EX, flush on mispredict.
// Optional statistics counters are built only when `BRQ_STATS_EN is defined.
module branch_resolve_queue #(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enq_valid1,
    input  logic                    enq_valid2,
    input  logic [31:0]             enq_pc1,
    input  logic [31:0]             enq_pc2,
    input  logic                    enq_taken1,
    input  logic                    enq_taken2,
    input  logic [31:0]             enq_target1,
    input  logic [31:0]             enq_target2,
    output logic                    enq_ready,
    input  logic                    res_valid1,
    input  logic                    res_valid2,
    input  logic                    res_taken1,
    input  logic                    res_taken2,
    input  logic [31:0]             res_target1,
    input  logic [31:0]             res_target2,
    output logic                    flush,
    output logic [31:0]             redirect_pc,
    output logic [$clog2(DEPTH):0]  count,
    output logic [31:0]             stat_resolved,
    output logic [31:0]             stat_mispredict
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_mem     [DEPTH];
    logic          taken_mem  [DEPTH];
    logic [31:0]   target_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic [PW-1:0] idx2;
    logic [PW-1:0] wr_idx2;
    logic          ev1;
    logic          ev2;
    logic          mp1;
    logic          mp2;
    logic          mispredict;
    logic          do_push;
    logic [31:0]   correct_pc;
    logic [CW-1:0] pops;
    logic [CW-1:0] pushes;

    function automatic logic is_mispredict(input logic pred_taken, input logic [31:0] pred_target,
                                           input logic act_taken, input logic [31:0] act_target);
        return (act_taken != pred_taken) || (act_taken && (act_target != pred_target));
    endfunction

    // Two free slots are always kept so a dual enqueue never has to be split.
    assign enq_ready = (count <= CW'(DEPTH - 2)) && !flush;

    always_comb begin
        ev1     = res_valid1 && (count != '0) && !flush;
        mp1     = ev1 && is_mispredict(taken_mem[head], target_mem[head], res_taken1, res_target1);
        idx2    = res_valid1 ? head + PW'(1) : head;
        ev2     = res_valid2 && !flush && !mp1 && (count > (res_valid1 ? CW'(1) : CW'(0)));
        mp2     = ev2 && is_mispredict(taken_mem[idx2], target_mem[idx2], res_taken2, res_target2);
        mispredict = mp1 || mp2;
        if (mp1)
            correct_pc = res_taken1 ? res_target1 : pc_mem[head] + 32'd4;
        else
            correct_pc = res_taken2 ? res_target2 : pc_mem[idx2] + 32'd4;
        do_push = enq_ready && !mispredict;
        pushes  = do_push ? (CW'(enq_valid1) + CW'(enq_valid2)) : '0;
        pops    = CW'(ev1) + CW'(ev2);
        wr_idx2 = enq_valid1 ? tail + PW'(1) : tail;
    end

    // A mispredict discards every in-flight entry, including any enqueued this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            flush <= mispredict;
            if (mispredict) begin
                redirect_pc <= correct_pc;
                head        <= tail;
                count       <= '0;
            end else begin
                head  <= head + PW'(pops);
                tail  <= tail + PW'(pushes);
                count <= count + pushes - pops;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            if (enq_valid1) begin
                pc_mem[tail]     <= enq_pc1;
                taken_mem[tail]  <= enq_taken1;
                target_mem[tail] <= enq_target1;
            end
            if (enq_valid2) begin
                pc_mem[wr_idx2]     <= enq_pc2;
                taken_mem[wr_idx2]  <= enq_taken2;
                target_mem[wr_idx2] <= enq_target2;
            end
        end
    end

`ifdef BRQ_STATS_EN
    // pops equals the number of pairs evaluated, even in a mispredict cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            stat_resolved   <= stat_resolved + 32'(pops);
            stat_mispredict <= stat_mispredict + 32'(mispredict);
        end
    end
`else
    assign stat_resolved   = '0;
    assign stat_mispredict = '0;
`endif

endmodule
